// File: rtl/vec_pkg.sv
// Shared parameters, state encoding and element helpers for the
// vector memory sequencer.
package vec_pkg;

  localparam int NELEM = 5;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int RAW   = 4;
  localparam int IW    = 3;

  localparam logic OP_VLD = 1'b0;
  localparam logic OP_VST = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_STORE,
    S_DONE
  } state_e;

  function automatic logic [DW-1:0] elem(
    input logic [NELEM*DW-1:0] v,
    input logic [IW-1:0]       i
  );
    return v[i*DW +: DW];
  endfunction

endpackage

// File: rtl/vec_elem_buf.sv
// NELEM x DW element buffer: async clear, parallel snapshot load,
// indexed single-element write, packed read-out.
module vec_elem_buf
  import vec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_i,
  input  logic [NELEM*DW-1:0] ld_data_i,
  input  logic                wr_i,
  input  logic [IW-1:0]       wr_idx_i,
  input  logic [DW-1:0]       wr_data_i,
  output logic [NELEM*DW-1:0] data_o
);

  logic [NELEM*DW-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (ld_i) begin
      data_d = ld_data_i;
    end else begin
      for (int i = 0; i < NELEM; i++) begin
        if (wr_i && wr_idx_i == IW'(i)) begin
          data_d[i*DW +: DW] = wr_data_i;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/vec_mem_seq.sv
// Multi-cycle VLD/VST sequencer between word memory and the
// vector register file; stalls the core through busy.
module vec_mem_seq
  import vec_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                op,
  input  logic [RAW-1:0]      vreg_idx,
  input  logic [AW-1:0]       base,
  output logic                busy,
  output logic                done,
  output logic [RAW-1:0]      vf_va,
  input  logic [NELEM*DW-1:0] vf_rd,
  output logic                vf_we,
  output logic [RAW-1:0]      vf_vd,
  output logic [NELEM*DW-1:0] vf_wd,
  output logic [AW-1:0]       mem_addr,
  output logic                mem_we,
  output logic [DW-1:0]       mem_wd,
  input  logic [DW-1:0]       mem_rd
);

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [RAW-1:0]      vreg_q, vreg_d;
  logic [AW-1:0]       base_q, base_d;
  logic [AW-1:0]       eaddr;
  logic                buf_ld, buf_wr;
  logic [NELEM*DW-1:0] buf_data;
  logic                last;

  assign eaddr = base_q + AW'({idx_q, 2'b00});
  assign last  = (idx_q == IW'(NELEM-1));

  vec_elem_buf u_buf (
    .clk       (clk),
    .rst       (reset),
    .ld_i      (buf_ld),
    .ld_data_i (vf_rd),
    .wr_i      (buf_wr),
    .wr_idx_i  (idx_q),
    .wr_data_i (mem_rd),
    .data_o    (buf_data)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    vreg_d   = vreg_q;
    base_d   = base_q;
    busy     = 1'b1;
    done     = 1'b0;
    vf_we    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    vf_va    = vreg_q;
    buf_ld   = 1'b0;
    buf_wr   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy  = 1'b0;
        vf_va = vreg_idx;
        if (start) begin
          vreg_d = vreg_idx;
          base_d = base & ~AW'(3);
          idx_d  = '0;
          // VST snapshots the source now so later writes can't leak in
          buf_ld  = (op == OP_VST);
          state_d = (op == OP_VST) ? S_STORE : S_LOAD;
        end
      end
      S_LOAD: begin
        mem_addr = eaddr;
        buf_wr   = 1'b1;
        idx_d    = idx_q + IW'(1);
        if (last) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        vf_we   = 1'b1;
        state_d = S_DONE;
      end
      S_STORE: begin
        mem_addr = eaddr;
        mem_we   = 1'b1;
        mem_wd   = elem(buf_data, idx_q);
        idx_d    = idx_q + IW'(1);
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vreg_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vreg_q  <= vreg_d;
      base_q  <= base_d;
    end
  end

  assign vf_vd = vreg_q;
  assign vf_wd = buf_data;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Randomized self-checking bench for vec_mem_seq with a simple
// memory/vector-file model and per-transfer event recording.
module tb_vec_mem_seq;
  import vec_pkg::*;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                op = 1'b0;
  logic [RAW-1:0]      vreg_idx = '0;
  logic [AW-1:0]       base = '0;
  logic                busy, done, vf_we, mem_we;
  logic [RAW-1:0]      vf_va, vf_vd;
  logic [NELEM*DW-1:0] vf_rd, vf_wd;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wd, mem_rd;

  vec_mem_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .vreg_idx(vreg_idx), .base(base), .busy(busy), .done(done),
    .vf_va(vf_va), .vf_rd(vf_rd), .vf_we(vf_we), .vf_vd(vf_vd),
    .vf_wd(vf_wd), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // memory: word content is a pure function of its address
  logic [31:0] m_bias = 32'hFFFF_FFC1;
  logic [31:0] m_xor  = 32'h0;
  assign mem_rd = ((mem_addr >> 2) + m_bias) ^ m_xor;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) + m_bias) ^ m_xor;
  endfunction

  // vector register file model
  logic [NELEM*DW-1:0] vregs [16];
  logic                force_en = 1'b0;
  logic [NELEM*DW-1:0] force_val = '0;
  logic                pl_en = 1'b0;
  logic [3:0]          pl_idx = '0;
  logic [NELEM*DW-1:0] pl_val = '0;
  assign vf_rd = force_en ? force_val : vregs[vf_va];

  always @(posedge clk) begin
    if (vf_we)      vregs[vf_vd] <= vf_wd;
    else if (pl_en) vregs[pl_idx] <= pl_val;
  end

  // event recorder, sampled mid-cycle
  int          cyc = 0;
  int          acc_cnt = 0, acc_cyc = 0;
  int          done_cnt = 0, done_cyc = 0;
  int          vwe_cnt = 0;
  logic [3:0]  vwe_vd;
  logic [159:0] vwe_wd;
  logic [31:0] ra_q[$], wa_q[$], wd_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (start && !busy) begin acc_cnt++; acc_cyc = cyc; end
      if (mem_we) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_wd);
      end
      if (busy && !mem_we && !vf_we && !done) ra_q.push_back(mem_addr);
      if (vf_we) begin vwe_cnt++; vwe_vd = vf_vd; vwe_wd = vf_wd; end
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic issue(input logic o, input logic [3:0] vi,
                       input logic [31:0] b);
    @(posedge clk); #1;
    ra_q.delete(); wa_q.delete(); wd_q.delete();
    vwe_cnt = 0;
    start = 1'b1; op = o; vreg_idx = vi; base = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); #1;
      if (done_cnt > d0) ok = 1'b1;
    end
  endtask

  task automatic preload(input logic [3:0] vi, input logic [159:0] v);
    @(posedge clk); #1;
    pl_idx = vi; pl_val = v; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vreg_idx = 4'd9;
    #1;
    n_checks++;
    if ({busy, done, vf_we, mem_we} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 0000",
               {busy, done, vf_we, mem_we});
    end
    n_checks++;
    if (mem_addr !== 0 || mem_wd !== 0 || vf_wd !== 0 || vf_vd !== 0) begin
      n_fail++;
      $display("FAIL reset_data got a=%h wd=%h vd=%h want 0",
               mem_addr, mem_wd, vf_vd);
    end
    n_checks++;
    if (vf_va !== 4'd9) begin
      n_fail++;
      $display("FAIL idle_vf_va got %0d want 9", vf_va);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_vld(input logic [3:0] vi, input logic [31:0] b);
    bit ok;
    logic [31:0] a, e;
    issue(OP_VLD, vi, b);
    wait_done(20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL vld_timeout got no done want done");
    end
    n_checks++;
    if (ra_q.size() != NELEM || wa_q.size() != 0) begin
      n_fail++;
      $display("FAIL vld_counts got rd=%0d wr=%0d want 5/0",
               ra_q.size(), wa_q.size());
    end
    for (int i = 0; i < NELEM; i++) begin
      a = (b & ~32'h3) + 32'(4 * i);
      e = mem_word(a);
      if (i < ra_q.size()) begin
        n_checks++;
        if (ra_q[i] !== a) begin
          n_fail++;
          $display("FAIL vld_addr%0d got %h want %h", i, ra_q[i], a);
        end
      end
      n_checks++;
      if (vwe_wd[i*DW +: DW] !== e) begin
        n_fail++;
        $display("FAIL vld_data%0d got %h want %h",
                 i, vwe_wd[i*DW +: DW], e);
      end
    end
    n_checks++;
    if (vwe_cnt !== 1 || vwe_vd !== vi) begin
      n_fail++;
      $display("FAIL vld_commit got n=%0d vd=%0d want 1/%0d",
               vwe_cnt, vwe_vd, vi);
    end
    n_checks++;
    if (done_cyc - acc_cyc !== NELEM + 2) begin
      n_fail++;
      $display("FAIL vld_latency got %0d want %0d",
               done_cyc - acc_cyc, NELEM + 2);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL vld_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_vst(input logic [3:0] vi, input logic [31:0] b,
                          input logic [159:0] v, input bit disturb);
    bit ok;
    logic [31:0] a;
    preload(vi, v);
    issue(OP_VST, vi, b);
    if (disturb) begin
      force_val = ~v;
      force_en = 1'b1;
    end
    wait_done(20, ok);
    force_en = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL vst_timeout got no done want done");
    end
    n_checks++;
    if (wa_q.size() != NELEM || vwe_cnt != 0) begin
      n_fail++;
      $display("FAIL vst_counts got wr=%0d vwe=%0d want 5/0",
               wa_q.size(), vwe_cnt);
    end
    for (int i = 0; i < NELEM && i < wa_q.size(); i++) begin
      a = (b & ~32'h3) + 32'(4 * i);
      n_checks++;
      if (wa_q[i] !== a || wd_q[i] !== v[i*DW +: DW]) begin
        n_fail++;
        $display("FAIL vst_elem%0d got %h:%h want %h:%h",
                 i, wa_q[i], wd_q[i], a, v[i*DW +: DW]);
      end
    end
    n_checks++;
    if (done_cyc - acc_cyc !== NELEM + 1) begin
      n_fail++;
      $display("FAIL vst_latency got %0d want %0d",
               done_cyc - acc_cyc, NELEM + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int d0;
    d0 = done_cnt;
    issue(OP_VLD, 4'd4, 32'h300);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, vf_we, mem_we} !== 4'b0 || mem_addr !== 0) begin
      n_fail++;
      $display("FAIL abort_state got %b a=%h want 0000 a=0",
               {busy, done, vf_we, mem_we}, mem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (vwe_cnt !== 0 || done_cnt !== d0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet got vwe=%0d done=%0d want 0/%0d",
               vwe_cnt, done_cnt, d0);
    end
    test_vld(4'd4, 32'h300);
  endtask

  task automatic test_start_held();
    bit ok;
    int a0;
    a0 = acc_cnt;
    vwe_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; op = OP_VLD; vreg_idx = 4'd6; base = 32'h400;
    wait_done(20, ok);
    n_checks++;
    if (!ok || acc_cnt !== a0 + 1) begin
      n_fail++;
      $display("FAIL held_first got ok=%b acc=%0d want 1/%0d",
               ok, acc_cnt - a0, 1);
    end
    @(negedge clk); #1;
    n_checks++;
    if (acc_cnt !== a0 + 2 || acc_cyc !== done_cyc + 1) begin
      n_fail++;
      $display("FAIL held_reaccept got acc=%0d gap=%0d want 2/1",
               acc_cnt - a0, acc_cyc - done_cyc);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, ok);
    n_checks++;
    if (!ok || acc_cnt !== a0 + 2 || vwe_cnt !== 2) begin
      n_fail++;
      $display("FAIL held_total got acc=%0d vwe=%0d want 2/2",
               acc_cnt - a0, vwe_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back(input logic [31:0] b1,
                                   input logic [31:0] b2);
    bit ok;
    logic [31:0] e;
    test_vld(4'd5, b1);
    issue(OP_VST, 4'd5, b2);
    wait_done(20, ok);
    n_checks++;
    if (!ok || wd_q.size() != NELEM) begin
      n_fail++;
      $display("FAIL b2b_vst got ok=%b n=%0d want 1/5", ok, wd_q.size());
    end
    for (int i = 0; i < NELEM && i < wd_q.size(); i++) begin
      e = mem_word((b1 & ~32'h3) + 32'(4 * i));
      n_checks++;
      if (wd_q[i] !== e) begin
        n_fail++;
        $display("FAIL b2b_elem%0d got %h want %h", i, wd_q[i], e);
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [159:0] rand_vec();
    logic [159:0] v;
    for (int i = 0; i < NELEM; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  initial begin
    test_reset();
    test_vld(4'd3, 32'h100);
    test_vst(4'd7, 32'h203,
             {32'hE, 32'hD, 32'hC, 32'hB, 32'hA}, 1'b0);
    m_bias = $urandom; m_xor = $urandom;
    test_vld(4'd1, 32'hFFFF_FFF8);
    test_reset_abort();
    test_start_held();
    test_vst(4'd2, $urandom, rand_vec(), 1'b1);
    for (int k = 0; k < 6; k++) begin
      m_bias = $urandom; m_xor = $urandom;
      test_vld(4'($urandom_range(0, 15)), $urandom);
      test_vst(4'($urandom_range(0, 15)), $urandom, rand_vec(),
               1'($urandom_range(0, 1)));
    end
    test_back_to_back($urandom, $urandom);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
